// File: rtl/apple_pkg.sv
// apple_pkg
//   Shared types and constants for the apple_field block: FSM state
//   encoding, LFSR seed and tap mask, the per-slot apple record, and
//   helpers for LFSR stepping and reset placement of slots.
package apple_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PICK,
      CHECK,
      PLACE
   } state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 (1-based) map to bits 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic       valid;
      logic [7:0] col;
      logic [7:0] row;
   } slot_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

   // Slot i starts valid at cell (2*i+1, 1).
   function automatic slot_t reset_slot(input int unsigned i);
      slot_t s;
      s.valid = 1'b1;
      s.col   = 8'(2 * i + 1);
      s.row   = 8'd1;
      return s;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16
//   Free-running 16-bit Fibonacci LFSR, advancing every clock.
//   Ports:
//     clk   - system clock
//     reset - asynchronous active-high reset, loads LFSR_SEED
//     value - current LFSR state
module lfsr16
   import apple_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] value
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   always_comb begin
      state_d = lfsr_next(state_q);
      // The all-zero state is a lock-up point; never enter it.
      if (state_d == '0) begin
         state_d = LFSR_SEED;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LFSR_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign value = state_q;

endmodule

// File: rtl/apple_field.sv
// apple_field
//   Holds N_APPLES apple slots on a GRID_W x GRID_H cell playfield, draws
//   them against the current pixel, and respawns an eaten apple at a
//   random free cell chosen from a free-running LFSR.
//   Optional feature macro: APPLE_BLINK_EN -- newly placed apples blink
//   for a few frames (per-slot 4-bit counter stepped by frame_tick).
//   Ports:
//     clk, reset      - clock, asynchronous active-high reset
//     x_pos, y_pos    - current pixel coordinate
//     frame_tick      - one-cycle pulse per video frame (blink only)
//     eat_valid/idx   - eat event for slot eat_idx
//     eat_ready       - high while an eat event can be accepted
//     spawn_done      - one-cycle pulse when a replacement is placed
//     apple_active    - current pixel lies inside a drawn apple
//     apple_idx       - slot of the hit (lowest index wins), else 0
//     rgb             - COLOR on a hit, else black
module apple_field
   import apple_pkg::*;
#(
   parameter int unsigned BIT      = 10,
   parameter int unsigned SIZE     = 20,
   parameter int unsigned N_APPLES = 3,
   parameter int unsigned GRID_W   = 32,
   parameter int unsigned GRID_H   = 24,
   parameter logic [2:0]  COLOR    = 3'b100
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [BIT-1:0] x_pos,
   input  logic [BIT-1:0] y_pos,
   input  logic           frame_tick,
   input  logic           eat_valid,
   input  logic [2:0]     eat_idx,
   output logic           eat_ready,
   output logic           spawn_done,
   output logic           apple_active,
   output logic [2:0]     apple_idx,
   output logic [2:0]     rgb
);

   state_e      state_q, state_d;
   slot_t       slot_q [N_APPLES];
   slot_t       slot_d [N_APPLES];
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  cand_col_q, cand_col_d;
   logic [7:0]  cand_row_q, cand_row_d;
   logic        spawn_done_q, spawn_done_d;

   logic [15:0]    lfsr_val;
   logic           cand_hit;
   logic           cand_bad;
   logic           drawn  [N_APPLES];
   logic [BIT-1:0] org_x  [N_APPLES];
   logic [BIT-1:0] org_y  [N_APPLES];

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .value (lfsr_val)
   );

   // ------------------------------------------------------------------
   // Optional blink counters
   // ------------------------------------------------------------------
`ifdef APPLE_BLINK_EN
   logic [3:0] blink_q [N_APPLES];
   logic [3:0] blink_d [N_APPLES];

   always_comb begin
      for (int unsigned i = 0; i < N_APPLES; i++) begin
         blink_d[i] = blink_q[i];
         if (state_q == PLACE && idx_q == 3'(i)) begin
            blink_d[i] = 4'd15;
         end else if (frame_tick && blink_q[i] != '0) begin
            blink_d[i] = blink_q[i] - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < N_APPLES; i++) begin
            blink_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_APPLES; i++) begin
            blink_q[i] <= blink_d[i];
         end
      end
   end

   // While blinking, the slot is shown only when counter bit 1 is clear.
   always_comb begin
      for (int unsigned i = 0; i < N_APPLES; i++) begin
         drawn[i] = slot_q[i].valid && (blink_q[i] == '0 || !blink_q[i][1]);
      end
   end
`else
   logic unused_frame_tick;
   assign unused_frame_tick = frame_tick;

   always_comb begin
      for (int unsigned i = 0; i < N_APPLES; i++) begin
         drawn[i] = slot_q[i].valid;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Pixel hit test
   // ------------------------------------------------------------------
   always_comb begin
      for (int unsigned i = 0; i < N_APPLES; i++) begin
         org_x[i] = BIT'(slot_q[i].col) * BIT'(SIZE);
         org_y[i] = BIT'(slot_q[i].row) * BIT'(SIZE);
      end
   end

   // Offset-from-origin form avoids overflow of origin+SIZE at BIT width.
   always_comb begin
      apple_active = 1'b0;
      apple_idx    = '0;
      for (int unsigned i = 0; i < N_APPLES; i++) begin
         if (!apple_active && drawn[i] &&
             x_pos >= org_x[i] && (x_pos - org_x[i]) < BIT'(SIZE) &&
             y_pos >= org_y[i] && (y_pos - org_y[i]) < BIT'(SIZE)) begin
            apple_active = 1'b1;
            apple_idx    = 3'(i);
         end
      end
   end

   assign rgb = apple_active ? COLOR : 3'b000;

   // ------------------------------------------------------------------
   // Candidate validation
   // ------------------------------------------------------------------
   // The eaten slot is already invalid, so it never blocks its own cell.
   always_comb begin
      cand_hit = 1'b0;
      for (int unsigned i = 0; i < N_APPLES; i++) begin
         if (slot_q[i].valid && slot_q[i].col == cand_col_q &&
             slot_q[i].row == cand_row_q) begin
            cand_hit = 1'b1;
         end
      end
      cand_bad = (32'(cand_col_q) >= GRID_W) ||
                 (32'(cand_row_q) >= GRID_H) || cand_hit;
   end

   // ------------------------------------------------------------------
   // Respawn FSM
   // ------------------------------------------------------------------
   assign eat_ready  = (state_q == IDLE);
   assign spawn_done = spawn_done_q;

   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      idx_d        = idx_q;
      cand_col_d   = cand_col_q;
      cand_row_d   = cand_row_q;
      spawn_done_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Out-of-range slot indices are silently dropped.
            if (eat_valid && 32'(eat_idx) < N_APPLES) begin
               for (int unsigned i = 0; i < N_APPLES; i++) begin
                  if (eat_idx == 3'(i)) begin
                     slot_d[i].valid = 1'b0;
                  end
               end
               idx_d   = eat_idx;
               state_d = PICK;
            end
         end
         PICK: begin
            cand_col_d = lfsr_val[7:0];
            cand_row_d = lfsr_val[15:8];
            state_d    = CHECK;
         end
         CHECK: begin
            state_d = cand_bad ? PICK : PLACE;
         end
         PLACE: begin
            for (int unsigned i = 0; i < N_APPLES; i++) begin
               if (idx_q == 3'(i)) begin
                  slot_d[i].valid = 1'b1;
                  slot_d[i].col   = cand_col_q;
                  slot_d[i].row   = cand_row_q;
               end
            end
            // Registered so the pulse coincides with the slot update.
            spawn_done_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cand_col_q   <= '0;
         cand_row_q   <= '0;
         spawn_done_q <= 1'b0;
         for (int unsigned i = 0; i < N_APPLES; i++) begin
            slot_q[i] <= reset_slot(i);
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cand_col_q   <= cand_col_d;
         cand_row_q   <= cand_row_d;
         spawn_done_q <= spawn_done_d;
         for (int unsigned i = 0; i < N_APPLES; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

endmodule

// File: tb/tb_apple_field.sv
// tb_apple_field
//   Directed self-checking bench for apple_field (default parameters).
//   Honours APPLE_BLINK_EN when the design is built with it.
module tb_apple_field;

`ifdef APPLE_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] x_pos = '0;
   logic [9:0] y_pos = '0;
   logic       frame_tick = 1'b0;
   logic       eat_valid = 1'b0;
   logic [2:0] eat_idx = '0;
   logic       eat_ready;
   logic       spawn_done;
   logic       apple_active;
   logic [2:0] apple_idx;
   logic [2:0] rgb;

   int checks = 0;
   int failures = 0;

   logic [15:0] m_lfsr;
   int m_valid [3];
   int m_col   [3];
   int m_row   [3];
   int m_cnt   [3];

   apple_field #(
      .BIT      (10),
      .SIZE     (20),
      .N_APPLES (3),
      .GRID_W   (32),
      .GRID_H   (24),
      .COLOR    (3'b100)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .x_pos        (x_pos),
      .y_pos        (y_pos),
      .frame_tick   (frame_tick),
      .eat_valid    (eat_valid),
      .eat_idx      (eat_idx),
      .eat_ready    (eat_ready),
      .spawn_done   (spawn_done),
      .apple_active (apple_active),
      .apple_idx    (apple_idx),
      .rgb          (rgb)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] nxt(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m_lfsr <= 16'hACE1;
      else       m_lfsr <= nxt(m_lfsr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_valid[i] = 1;
         m_col[i]   = 2 * i + 1;
         m_row[i]   = 1;
         m_cnt[i]   = 0;
      end
   endtask

   function automatic bit m_drawn(input int i);
      if (m_valid[i] == 0) return 1'b0;
      if (!BLINK) return 1'b1;
      return (m_cnt[i] == 0) || (((m_cnt[i] >> 1) & 1) == 0);
   endfunction

   task automatic probe(input string tag, input int x, input int y);
      int exp_act;
      int exp_idx;
      x_pos = 10'(x);
      y_pos = 10'(y);
      #1;
      exp_act = 0;
      exp_idx = 0;
      for (int i = 0; i < 3; i++) begin
         if (exp_act == 0 && m_drawn(i) &&
             x >= m_col[i] * 20 && x < m_col[i] * 20 + 20 &&
             y >= m_row[i] * 20 && y < m_row[i] * 20 + 20) begin
            exp_act = 1;
            exp_idx = i;
         end
      end
      chk({tag, "_active"}, 32'(apple_active), 32'(exp_act));
      chk({tag, "_idx"},    32'(apple_idx),    32'(exp_idx));
      chk({tag, "_rgb"},    32'(rgb),          (exp_act != 0) ? 32'd4 : 32'd0);
   endtask

   // Candidate k is the LFSR value two clocks after candidate k-1;
   // candidate 0 is the value one clock after the accept edge.
   task automatic predict(input int idx, output int c, output int r, output int retries);
      logic [15:0] v;
      bit ok;
      v = nxt(m_lfsr);
      retries = 0;
      c = 0;
      r = 0;
      for (int k = 0; k < 10000; k++) begin
         c = int'(v[7:0]);
         r = int'(v[15:8]);
         ok = (c < 32) && (r < 24);
         for (int j = 0; j < 3; j++) begin
            if (j != idx && m_valid[j] != 0 && m_col[j] == c && m_row[j] == r) ok = 1'b0;
         end
         if (ok) break;
         v = nxt(nxt(v));
         retries++;
      end
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      for (int i = 0; i < 3; i++) if (m_cnt[i] > 0) m_cnt[i]--;
   endtask

   task automatic do_eat(input string tag, input int idx, output int lat);
      int pc, pr, pretries, oc, orow;
      predict(idx, pc, pr, pretries);
      oc = m_col[idx];
      orow = m_row[idx];
      eat_valid = 1'b1;
      eat_idx   = 3'(idx);
      tick();
      eat_valid = 1'b0;
      m_valid[idx] = 0;
      chk({tag, "_ready_low"}, 32'(eat_ready), 32'd0);
      probe({tag, "_gone"}, oc * 20 + 10, orow * 20 + 10);
      // A busy-time eat of another slot must be ignored.
      eat_valid = 1'b1;
      eat_idx   = 3'((idx + 1) % 3);
      tick();
      eat_valid = 1'b0;
      lat = 1;
      while (spawn_done !== 1'b1 && lat < 20000) begin
         tick();
         lat++;
      end
      chk({tag, "_spawn"}, 32'(spawn_done), 32'd1);
      chk({tag, "_latency"}, 32'(lat), 32'(3 + 2 * pretries));
      m_valid[idx] = 1;
      m_col[idx]   = pc;
      m_row[idx]   = pr;
      if (BLINK) m_cnt[idx] = 15;
      probe({tag, "_new"}, pc * 20 + 19, pr * 20);
      probe({tag, "_old"}, oc * 20 + 10, orow * 20 + 10);
      for (int i = 0; i < 3; i++) begin
         if (i != idx) probe({tag, "_other"}, m_col[i] * 20 + 3, m_row[i] * 20 + 17);
      end
      tick();
      chk({tag, "_spawn_pulse"}, 32'(spawn_done), 32'd0);
      chk({tag, "_ready_back"}, 32'(eat_ready), 32'd1);
   endtask

   initial begin
      int lat;
      int d;
      logic [15:0] v;

      model_reset();
      tick();
      tick();
      reset = 1'b0;

      chk("rst_ready", 32'(eat_ready), 32'd1);
      chk("rst_spawn", 32'(spawn_done), 32'd0);
      probe("rst_slot1", 60, 25);
      probe("rst_empty", 40, 25);
      probe("rst_slot0", 25, 25);
      tick();
      probe("rst_slot2", 105, 25);
      probe("edge_br", 79, 39);
      probe("edge_right", 80, 25);
      tick();
      probe("edge_left", 59, 25);
      probe("edge_top", 65, 19);
      probe("edge_bottom", 65, 40);
      tick();

      do_eat("eat0", 0, lat);

      // Steer the first candidate to column 40 (off-grid) to force a retry.
      v = nxt(m_lfsr);
      d = 0;
      while (v[7:0] != 8'd40 && d < 4000) begin
         v = nxt(v);
         d++;
      end
      if (d >= 4000) begin
         v = nxt(m_lfsr);
         d = 0;
         while (v[7:0] < 8'd32) begin
            v = nxt(v);
            d++;
         end
      end
      repeat (d) tick();
      do_eat("eat2", 2, lat);
      chk("eat2_retry", 32'(lat >= 5), 32'd1);

      for (int k = 0; k <= 16; k++) begin
         probe("blink", m_col[2] * 20 + 5, m_row[2] * 20 + 5);
         frame();
      end
      probe("blink_done", m_col[2] * 20 + 12, m_row[2] * 20 + 12);

      eat_valid = 1'b1;
      eat_idx   = 3'd5;
      tick();
      eat_valid = 1'b0;
      chk("bad_idx_ready", 32'(eat_ready), 32'd1);
      chk("bad_idx_spawn", 32'(spawn_done), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bad_idx_nospawn", 32'(spawn_done), 32'd0);
      end
      for (int i = 0; i < 3; i++) probe("bad_idx_slot", m_col[i] * 20 + 10, m_row[i] * 20 + 10);
      tick();

      eat_valid = 1'b1;
      eat_idx   = 3'd1;
      tick();
      eat_valid = 1'b0;
      m_valid[1] = 0;
      tick();
      chk("mid_busy", 32'(eat_ready), 32'd0);
      reset = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_ready", 32'(eat_ready), 32'd1);
      chk("mid_rst_spawn", 32'(spawn_done), 32'd0);
      tick();
      reset = 1'b0;
      probe("mid_slot0", 25, 25);
      probe("mid_slot1", 65, 25);
      probe("mid_slot2", 105, 25);
      tick();
      chk("mid_ready", 32'(eat_ready), 32'd1);
      chk("mid_spawn", 32'(spawn_done), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apple_field.md
APPLE_FIELD -- requirements
Module: apple_field

Interface
REQ-001 Param BIT, default 10, pixel coordinate width.
REQ-002 Param SIZE, default 20, apple edge and grid cell size in px.
REQ-003 Param N_APPLES, default 3, number of apple slots (1..8).
REQ-004 Param GRID_W, default 32, playfield width in cells; SHALL be >= 2*N_APPLES+1 and <= 256.
REQ-005 Param GRID_H, default 24, playfield height in cells; SHALL be >= 2 and <= 256.
REQ-006 Param COLOR, default 3'b100, apple rgb.
REQ-007 clk  in  1  system clock. The clock is clk; reset is reset, asynchronous, active-high.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 x_pos, y_pos  in  BIT  current pixel.
REQ-010 frame_tick  in  1  one-cycle pulse per video frame.
REQ-011 eat_valid  in  1  snake head has eaten apple eat_idx.
REQ-012 eat_idx  in  3  slot index being eaten.
REQ-013 eat_ready  out  1  block can accept an eat event.
REQ-014 spawn_done  out  1  one-cycle pulse when a replacement apple is placed.
REQ-015 apple_active  out  1  current pixel lies inside a drawn apple.
REQ-016 apple_idx  out  3  slot of the hit; 0 when apple_active=0.
REQ-017 rgb  out  3  COLOR when apple_active, else 3'b000.

Function
REQ-018 Each slot SHALL hold valid bit, col (8b), row (8b); pixel origin = col*SIZE, row*SIZE, computed at BIT width.
REQ-019 Hit test SHALL be combinational: x in [col*SIZE, col*SIZE+SIZE), y likewise, slot valid and drawn; the lowest index wins.
REQ-020 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1, SHALL advance every clock, never all-zero.
REQ-021 FSM states IDLE, PICK, CHECK, PLACE; eat_ready=1 only in IDLE.
REQ-022 Transfer when eat_valid && eat_ready: if eat_idx<N_APPLES, clear slot valid, latch idx, go PICK; else drop the event and stay in IDLE with no spawn_done.
REQ-023 PICK: cand_col=lfsr[7:0], cand_row=lfsr[15:8]; go CHECK.
REQ-024 CHECK: if cand_col>=GRID_W or cand_row>=GRID_H or the candidate equals any other valid slot's cell, go PICK (retry); else go PLACE.
REQ-025 PLACE: write the candidate, set valid, pulse spawn_done, go IDLE; minimum accept-to-spawn_done latency is 3 cycles.
REQ-026 eat_valid while not ready SHALL be ignored, not queued.
REQ-027 A slot cleared by eating SHALL stop drawing in the cycle after the transfer.

Reset
REQ-028 On reset, slot i SHALL be valid at col=2*i+1, row=1.
REQ-029 Reset SHALL put the FSM in IDLE and the LFSR at seed, with eat_ready=1 and spawn_done=0; reset mid-respawn SHALL abort it and restore all slots.

Configuration
REQ-030 With APPLE_BLINK_EN defined: each slot has a 4-bit blink counter, loaded with 15 at PLACE and decremented on frame_tick while nonzero.
REQ-031 With APPLE_BLINK_EN defined: while the counter is nonzero, the slot is drawn only when counter[1]=0; reset counters are 0.
REQ-032 Without APPLE_BLINK_EN: no counters exist, frame_tick is unused, and every valid slot is always drawn.

Structure
REQ-033 Package apple_pkg SHALL hold the FSM state enum, LFSR seed, tap mask and slot record typedef.
REQ-034 Sub-module lfsr16 (free-running LFSR, seed via reset) SHALL be instantiated once.

Verification
REQ-035 After reset, x=60,y=25 -> apple_active=1, apple_idx=1, rgb=3'b100; x=40,y=25 -> 0.
REQ-036 eat_valid=1, eat_idx=0 in IDLE -> eat_ready drops next cycle; slot 0 is not drawn; spawn_done within >=3 cycles; the new cell is in range and distinct from slots 1 and 2.
REQ-037 Force the LFSR to give col=40 (>=32) -> at least one PICK/CHECK retry before PLACE.
REQ-038 eat_idx=5 with N_APPLES=3 -> no slot change, no spawn_done, eat_ready stays 1.
REQ-039 Assert reset during CHECK -> next cycle slots are back at (1,1),(3,1),(5,1), FSM is IDLE and eat_ready=1.
REQ-040 With APPLE_BLINK_EN: after PLACE, 16 frame_ticks -> the slot alternates hidden/shown by counter[1], then stays drawn.
